telemetry_tx: RTL and testbench

Telemetry frame transmitter and readout side of the coordinate/time register bank. On request it snapshots the stored X, Y, Z and T bytes. It then serializes them onto a single-wire UART-style line as a fixed 6-byte frame: sync, X, Y, Z, T, checksum. It sits between the coordinate/time holding registers and the downlink pin.

---
 rtl/telemetry_tx_if.sv | 23 ++
 rtl/telemetry_tx.sv | 148 ++++++++++++++
 tb/tb_telemetry_tx.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/telemetry_tx_if.sv
// Connects the coordinate/time holding registers, the frame request handshake
// and the downlink serial line to telemetry_tx.
interface telemetry_tx_if;
  logic [7:0] x_in;
  logic [7:0] y_in;
  logic [7:0] z_in;
  logic [7:0] t_in;
  logic       start;
  logic       ready;
  logic       tx;
  logic       done;
  logic [2:0] byte_idx;

  modport master (
    output x_in, y_in, z_in, t_in, start,
    input  ready, tx, done, byte_idx
  );

  modport slave (
    input  x_in, y_in, z_in, t_in, start,
    output ready, tx, done, byte_idx
  );
endinterface

// File: rtl/telemetry_tx.sv
// Snapshots X/Y/Z/T on request and sends a 6-byte UART-style frame:
// sync, X, Y, Z, T, checksum (8N1, LSB first, CLKS_PER_BIT cycles per bit).
module telemetry_tx #(
  parameter int         CLKS_PER_BIT = 4,
  parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
  input logic           clk,
  input logic           rst,
  telemetry_tx_if.slave bus
);

  typedef enum logic [1:0] {IDLE, START_BIT, DATA, STOP_BIT} state_e;

  localparam logic [7:0] CYC_LAST = 8'(CLKS_PER_BIT - 1);

  state_e     state_q, state_d;
  logic [7:0] cyc_q, cyc_d;
  logic [2:0] bit_q, bit_d;
  logic [2:0] byte_q, byte_d;
  logic [7:0] x_q, x_d, y_q, y_d, z_q, z_d, t_q, t_d, chk_q, chk_d;
  logic       tx_q, tx_d;
  logic       done_q, done_d;
  logic       cyc_wrap;
  logic [7:0] cur_byte;

  assign cyc_wrap = (cyc_q == CYC_LAST);

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    t_d     = t_q;
    chk_d   = chk_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          x_d     = bus.x_in;
          y_d     = bus.y_in;
          z_d     = bus.z_in;
          t_d     = bus.t_in;
          // 8-bit addition wraps, giving the sum mod 256 directly
          chk_d   = bus.x_in + bus.y_in + bus.z_in + bus.t_in;
          cyc_d   = 8'd0;
          bit_d   = 3'd0;
          byte_d  = 3'd0;
          state_d = START_BIT;
        end
      end
      START_BIT: begin
        if (cyc_wrap) begin
          cyc_d   = 8'd0;
          bit_d   = 3'd0;
          state_d = DATA;
        end else begin
          cyc_d = cyc_q + 8'd1;
        end
      end
      DATA: begin
        if (cyc_wrap) begin
          cyc_d = 8'd0;
          if (bit_q == 3'd7) begin
            state_d = STOP_BIT;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cyc_d = cyc_q + 8'd1;
        end
      end
      STOP_BIT: begin
        if (cyc_wrap) begin
          cyc_d = 8'd0;
          if (byte_q < 3'd5) begin
            byte_d  = byte_q + 3'd1;
            state_d = START_BIT;
          end else begin
            byte_d  = 3'd0;
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end else begin
          cyc_d = cyc_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // tx is computed from the next state so the line changes exactly on the bit boundary
  always_comb begin
    case (byte_d)
      3'd0:    cur_byte = SYNC_BYTE;
      3'd1:    cur_byte = x_d;
      3'd2:    cur_byte = y_d;
      3'd3:    cur_byte = z_d;
      3'd4:    cur_byte = t_d;
      default: cur_byte = chk_d;
    endcase
  end

  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      START_BIT: tx_d = 1'b0;
      DATA:      tx_d = cur_byte[bit_d];
      default:   tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cyc_q   <= 8'd0;
      bit_q   <= 3'd0;
      byte_q  <= 3'd0;
      x_q     <= 8'd0;
      y_q     <= 8'd0;
      z_q     <= 8'd0;
      t_q     <= 8'd0;
      chk_q   <= 8'd0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      t_q     <= t_d;
      chk_q   <= chk_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

  assign bus.ready    = (state_q == IDLE);
  assign bus.tx       = tx_q;
  assign bus.done     = done_q;
  assign bus.byte_idx = byte_q;

endmodule

// File: tb/tb_telemetry_tx.sv
// Self-checking bench for telemetry_tx: a CLKS_PER_BIT=4 instance for frame content
// and reset behaviour, and a CLKS_PER_BIT=1 instance for back-to-back framing.
module tb_telemetry_tx;

  logic clk = 1'b0;
  logic rst4, rst1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  telemetry_tx_if bus4 ();
  telemetry_tx_if bus1 ();

  telemetry_tx #(.CLKS_PER_BIT(4), .SYNC_BYTE(8'hA5)) dut4 (.clk(clk), .rst(rst4), .bus(bus4.slave));
  telemetry_tx #(.CLKS_PER_BIT(1), .SYNC_BYTE(8'hA5)) dut1 (.clk(clk), .rst(rst1), .bus(bus1.slave));

  // Frame as 6 bytes, byte b at bits [b*8 +: 8]
  function automatic logic [47:0] model_frame(input logic [7:0] x, y, z, t);
    int sum;
    sum = int'(x) + int'(y) + int'(z) + int'(t);
    return {8'(sum % 256), t, z, y, x, 8'hA5};
  endfunction

  // Line level for serial bit n (0..59) of a frame: 10 bits per byte, start=0, stop=1
  function automatic logic model_tx(input logic [47:0] f, input int n);
    int b, p;
    b = n / 10;
    p = n % 10;
    if (p == 0) return 1'b0;
    if (p == 9) return 1'b1;
    return f[b*8 + p - 1];
  endfunction

  task automatic frame_check(input logic [7:0] x, y, z, t, input bit busy_poke, input string name);
    logic [47:0] f;
    logic [0:239] obs, expv;
    logic [7:0] dec;
    int ready_low, done_hits, idx_bad;
    f = model_frame(x, y, z, t);
    ready_low = 0; done_hits = 0; idx_bad = 0;
    @(negedge clk);
    checks++;
    if (bus4.ready !== 1'b1) begin
      errors++; $display("[TB] FAIL %s ready_before: got %b want 1", name, bus4.ready);
    end
    bus4.x_in = x; bus4.y_in = y; bus4.z_in = z; bus4.t_in = t; bus4.start = 1'b1;
    for (int c = 1; c <= 240; c++) begin
      @(negedge clk);
      if (c == 1) begin
        bus4.start = 1'b0;
        bus4.x_in = 8'($urandom);
      end
      obs[c-1]  = bus4.tx;
      expv[c-1] = model_tx(f, (c - 1) / 4);
      if (bus4.ready === 1'b0) ready_low++;
      if (bus4.done !== 1'b0) done_hits++;
      if (bus4.byte_idx !== 3'((c - 1) / 40)) idx_bad++;
      if (busy_poke && (c == 10 || c == 100)) begin
        bus4.x_in = 8'h99; bus4.start = 1'b1;
      end else if (busy_poke && (c == 11 || c == 101)) begin
        bus4.start = 1'b0;
      end
    end
    checks++;
    if (obs !== expv) begin
      errors++; $display("[TB] FAIL %s tx_stream: got %h want %h", name, obs, expv);
    end
    for (int b = 0; b < 6; b++) begin
      for (int k = 0; k < 8; k++) dec[k] = obs[(b*10 + 1 + k)*4 + 2];
      checks++;
      if (dec !== f[b*8 +: 8]) begin
        errors++; $display("[TB] FAIL %s byte%0d: got %h want %h", name, b, dec, f[b*8 +: 8]);
      end
    end
    checks++;
    if (ready_low !== 240) begin
      errors++; $display("[TB] FAIL %s ready_low_cycles: got %0d want 240", name, ready_low);
    end
    checks++;
    if (done_hits !== 0 || idx_bad !== 0) begin
      errors++; $display("[TB] FAIL %s early_done/byte_idx: got done=%0d idx_bad=%0d want 0/0", name, done_hits, idx_bad);
    end
    @(negedge clk);
    checks++;
    if ({bus4.done, bus4.ready, bus4.tx, bus4.byte_idx} !== 6'b111_000) begin
      errors++; $display("[TB] FAIL %s end_cycle241: got done=%b ready=%b tx=%b idx=%0d want 1 1 1 0",
                         name, bus4.done, bus4.ready, bus4.tx, bus4.byte_idx);
    end
    @(negedge clk);
    checks++;
    if ({bus4.done, bus4.ready, bus4.tx} !== 3'b011) begin
      errors++; $display("[TB] FAIL %s after_done: got done=%b ready=%b tx=%b want 0 1 1",
                         name, bus4.done, bus4.ready, bus4.tx);
    end
  endtask

  task automatic test_reset;
    int bad;
    bad = 0;
    bus4.start = 1'b1; bus1.start = 1'b1;
    bus4.x_in = 8'h00; bus4.y_in = 8'h00; bus4.z_in = 8'h00; bus4.t_in = 8'h00;
    bus1.x_in = 8'h00; bus1.y_in = 8'h00; bus1.z_in = 8'h00; bus1.t_in = 8'h00;
    rst4 = 1'b1; rst1 = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus4.tx, bus4.ready, bus4.done, bus4.byte_idx} !== 6'b110_000) begin
      errors++; $display("[TB] FAIL reset_override_start: got tx=%b ready=%b done=%b idx=%0d want 1 1 0 0",
                         bus4.tx, bus4.ready, bus4.done, bus4.byte_idx);
    end
    bus4.start = 1'b0; bus1.start = 1'b0;
    rst4 = 1'b0; rst1 = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if ({bus4.tx, bus4.ready, bus4.done, bus4.byte_idx} !== 6'b110_000) bad++;
      if ({bus1.tx, bus1.ready, bus1.done, bus1.byte_idx} !== 6'b110_000) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++; $display("[TB] FAIL reset_idle_hold: got %0d bad cycles want 0", bad);
    end
  endtask

  task automatic test_basic_frame;
    frame_check(8'h12, 8'h34, 8'h56, 8'h78, 1'b0, "basic");
  endtask

  task automatic test_checksum_wrap;
    frame_check(8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b0, "chk_ff");
    frame_check(8'h00, 8'h00, 8'h00, 8'h00, 1'b0, "chk_00");
  endtask

  task automatic test_snapshot_busy;
    frame_check(8'h3C, 8'hC3, 8'h81, 8'h7E, 1'b1, "snapshot_busy");
  endtask

  task automatic test_random_frames;
    for (int i = 0; i < 4; i++)
      frame_check(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'b0, "random");
  endtask

  task automatic test_reset_mid_frame;
    int done_hits;
    done_hits = 0;
    @(negedge clk);
    bus4.x_in = 8'($urandom); bus4.y_in = 8'($urandom); bus4.z_in = 8'($urandom); bus4.t_in = 8'($urandom);
    bus4.start = 1'b1;
    for (int c = 1; c <= 130; c++) begin
      @(negedge clk);
      if (c == 1) bus4.start = 1'b0;
      if (bus4.done !== 1'b0) done_hits++;
    end
    checks++;
    if (bus4.byte_idx !== 3'd3) begin
      errors++; $display("[TB] FAIL midreset_position: got idx=%0d want 3", bus4.byte_idx);
    end
    rst4 = 1'b1;
    @(negedge clk);
    rst4 = 1'b0;
    checks++;
    if ({bus4.tx, bus4.ready, bus4.done, bus4.byte_idx} !== 6'b110_000) begin
      errors++; $display("[TB] FAIL midreset_next: got tx=%b ready=%b done=%b idx=%0d want 1 1 0 0",
                         bus4.tx, bus4.ready, bus4.done, bus4.byte_idx);
    end
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (bus4.done !== 1'b0 || bus4.tx !== 1'b1) done_hits++;
    end
    checks++;
    if (done_hits !== 0) begin
      errors++; $display("[TB] FAIL midreset_quiet: got %0d done/tx events want 0", done_hits);
    end
    frame_check(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'b0, "after_midreset");
  endtask

  task automatic test_back_to_back;
    logic [47:0] f;
    int tx_bad, done_bad, done_total, ready_bad, p;
    f = model_frame(8'hDE, 8'hAD, 8'hBE, 8'hEF);
    tx_bad = 0; done_bad = 0; done_total = 0; ready_bad = 0;
    @(negedge clk);
    bus1.x_in = 8'hDE; bus1.y_in = 8'hAD; bus1.z_in = 8'hBE; bus1.t_in = 8'hEF;
    bus1.start = 1'b1;
    // Each frame: 60 line cycles then the done cycle, in which the next start is accepted
    for (int c = 1; c <= 183; c++) begin
      @(negedge clk);
      p = (c - 1) % 61;
      if (bus1.done === 1'b1) done_total++;
      if (p < 60) begin
        if (bus1.tx !== model_tx(f, p)) tx_bad++;
        if (bus1.done !== 1'b0) done_bad++;
        if (bus1.ready !== 1'b0) ready_bad++;
      end else begin
        if (bus1.tx !== 1'b1) tx_bad++;
        if (bus1.done !== 1'b1) done_bad++;
        if (bus1.ready !== 1'b1) ready_bad++;
      end
      if (c == 183) bus1.start = 1'b0;
    end
    checks++;
    if (tx_bad !== 0) begin
      errors++; $display("[TB] FAIL b2b_tx_stream: got %0d bad cycles want 0", tx_bad);
    end
    checks++;
    if (done_total !== 3 || done_bad !== 0) begin
      errors++; $display("[TB] FAIL b2b_done: got pulses=%0d misplaced=%0d want 3/0", done_total, done_bad);
    end
    checks++;
    if (ready_bad !== 0) begin
      errors++; $display("[TB] FAIL b2b_ready: got %0d bad cycles want 0", ready_bad);
    end
    @(negedge clk);
    checks++;
    if ({bus1.tx, bus1.ready, bus1.done} !== 3'b110) begin
      errors++; $display("[TB] FAIL b2b_stop: got tx=%b ready=%b done=%b want 1 1 0", bus1.tx, bus1.ready, bus1.done);
    end
  endtask

  initial begin
    rst4 = 1'b1; rst1 = 1'b1;
    bus4.start = 1'b0; bus1.start = 1'b0;
    test_reset();
    test_basic_frame();
    test_checksum_wrap();
    test_snapshot_busy();
    test_random_frames();
    test_reset_mid_frame();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
